// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, datapath mux codes,
// opcode values and the opcode-to-instruction-class decoder.
package multicycle_control_unit_pkg;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    IC_ARITH     = 4'd0,
    IC_ARITH_IMM = 4'd1,
    IC_LOAD      = 4'd2,
    IC_STORE     = 4'd3,
    IC_BRANCH    = 4'd4,
    IC_JAL       = 4'd5,
    IC_JALR      = 4'd6,
    IC_ECALL     = 4'd7,
    IC_UNKNOWN   = 4'd8
  } instr_class_e;

  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM    = 7'b1110011;

  localparam logic [1:0] PC_SRC_PC4    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_ALURES = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
  localparam logic [1:0] ALU_OP_ITYPE  = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_source;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       pc_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_strobes_t;

  function automatic instr_class_e decode_opcode(input logic [6:0] op);
    instr_class_e cls;
    case (op)
      OP_ARITH:     cls = IC_ARITH;
      OP_ARITH_IMM: cls = IC_ARITH_IMM;
      OP_LOAD:      cls = IC_LOAD;
      OP_STORE:     cls = IC_STORE;
      OP_BRANCH:    cls = IC_BRANCH;
      OP_JAL:       cls = IC_JAL;
      OP_JALR:      cls = IC_JALR;
      OP_SYSTEM:    cls = IC_ECALL;
      default:      cls = IC_UNKNOWN;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Bundle between the control unit (master) and the multicycle datapath (slave):
// opcode/status inputs to the controller and all datapath strobes back out.
interface multicycle_control_unit_if;

  logic [6:0] opcode;
  logic       bcond;
  logic       ecall_halt;
  logic       mem_ready;

  logic       pc_write;
  logic [1:0] pc_source;
  logic       ir_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       mem_to_reg;
  logic       pc_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       is_halted;
  logic [2:0] state;

  modport master (
    input  opcode, bcond, ecall_halt, mem_ready,
    output pc_write, pc_source, ir_write, i_or_d, mem_read, mem_write,
           mem_to_reg, pc_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           is_halted, state
  );

  modport slave (
    output opcode, bcond, ecall_halt, mem_ready,
    input  pc_write, pc_source, ir_write, i_or_d, mem_read, mem_write,
           mem_to_reg, pc_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           is_halted, state
  );

endinterface

// File: rtl/multicycle_control_unit_mem_wait_timer.sv
// Memory-phase completion: either the mem_ready handshake or a fixed MEM_LATENCY count
// (legal 1..15) on a 4-bit counter that restarts on every controller state change.
module multicycle_control_unit_mem_wait_timer #(
  parameter int USE_MEM_READY = 1,
  parameter int MEM_LATENCY   = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic state_change,
  input  logic mem_ready,
  output logic done
);

  localparam logic [3:0] LAT_LAST = 4'(MEM_LATENCY - 1);

  logic [3:0] wait_cnt_r;
  logic       done_s;

  // Wait counter: restarts on state change, saturates at 15.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_r <= 4'd0;
    end else if (state_change) begin
      wait_cnt_r <= 4'd0;
    end else if (wait_cnt_r != 4'd15) begin
      wait_cnt_r <= wait_cnt_r + 4'd1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Completion select for the two memory timing modes.
  always_comb begin
    done_s = 1'b0;
    if (USE_MEM_READY != 0) begin
      done_s = mem_ready;
    end else begin
      done_s = (wait_cnt_r == LAT_LAST);
    end
  end

  assign done = done_s;

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM (IF/ID/EX/MEM/WB/HALT) driving the shared datapath strobes.
// Optional performance counters are enabled with `define CTRL_PERF_CNT_EN.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int USE_MEM_READY = 1,
  parameter int MEM_LATENCY   = 1
`ifdef CTRL_PERF_CNT_EN
  ,
  parameter int CNT_WIDTH     = 32
`endif
) (
  input  logic                       clk,
  input  logic                       reset_n,
  multicycle_control_unit_if.master  bus
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]       cycle_count,
  output logic [CNT_WIDTH-1:0]       instr_count
`endif
);

  state_e        state_r;
  state_e        next_s;
  instr_class_e  cls_s;
  ctrl_strobes_t ctrl_s;
  ctrl_strobes_t strb_s;
  logic          done_s;
  logic          state_change_s;
  logic          is_halted_r;

  assign cls_s          = decode_opcode(bus.opcode);
  assign state_change_s = (next_s != state_r);

  multicycle_control_unit_mem_wait_timer #(
    .USE_MEM_READY (USE_MEM_READY),
    .MEM_LATENCY   (MEM_LATENCY)
  ) u_mem_wait_timer (
    .clk          (clk),
    .reset_n      (reset_n),
    .state_change (state_change_s),
    .mem_ready    (bus.mem_ready),
    .done         (done_s)
  );

  // State register and sticky halt flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IF;
      is_halted_r <= 1'b0;
    end else begin
      state_r     <= next_s;
      is_halted_r <= is_halted_r | (next_s == ST_HALT);
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    next_s = state_r;
    ctrl_s = '0;
    case (state_r)
      ST_IF: begin
        ctrl_s.mem_read = 1'b1;
        if (done_s) begin
          ctrl_s.ir_write = 1'b1;
          next_s          = ST_ID;
        end else begin
          next_s = ST_IF;
        end
      end
      ST_ID: begin
        // Branch/JAL target is precomputed here into ALUOut.
        ctrl_s.alu_src_b = SRC_B_IMM;
        ctrl_s.alu_op    = ALU_OP_ADD;
        case (cls_s)
          IC_ECALL: begin
            if (bus.ecall_halt) begin
              next_s = ST_HALT;
            end else begin
              ctrl_s.pc_write  = 1'b1;
              ctrl_s.pc_source = PC_SRC_PC4;
              next_s           = ST_IF;
            end
          end
          IC_UNKNOWN: begin
            ctrl_s.pc_write  = 1'b1;
            ctrl_s.pc_source = PC_SRC_PC4;
            next_s           = ST_IF;
          end
          default: next_s = ST_EX;
        endcase
      end
      ST_EX: begin
        ctrl_s.alu_src_a = 1'b1;
        case (cls_s)
          IC_ARITH: begin
            ctrl_s.alu_op    = ALU_OP_RTYPE;
            ctrl_s.alu_src_b = SRC_B_RS2;
            next_s           = ST_WB;
          end
          IC_ARITH_IMM: begin
            ctrl_s.alu_op    = ALU_OP_ITYPE;
            ctrl_s.alu_src_b = SRC_B_IMM;
            next_s           = ST_WB;
          end
          IC_LOAD, IC_STORE: begin
            ctrl_s.alu_op    = ALU_OP_ADD;
            ctrl_s.alu_src_b = SRC_B_IMM;
            next_s           = ST_MEM;
          end
          IC_BRANCH: begin
            ctrl_s.alu_op    = ALU_OP_BRANCH;
            ctrl_s.alu_src_b = SRC_B_RS2;
            ctrl_s.pc_write  = 1'b1;
            ctrl_s.pc_source = bus.bcond ? PC_SRC_ALUOUT : PC_SRC_PC4;
            next_s           = ST_IF;
          end
          IC_JAL: begin
            ctrl_s.alu_src_a = 1'b0;
            ctrl_s.reg_write = 1'b1;
            ctrl_s.pc_to_reg = 1'b1;
            ctrl_s.pc_write  = 1'b1;
            ctrl_s.pc_source = PC_SRC_ALUOUT;
            next_s           = ST_IF;
          end
          IC_JALR: begin
            ctrl_s.alu_src_b = SRC_B_IMM;
            ctrl_s.reg_write = 1'b1;
            ctrl_s.pc_to_reg = 1'b1;
            ctrl_s.pc_write  = 1'b1;
            ctrl_s.pc_source = PC_SRC_ALURES;
            next_s           = ST_IF;
          end
          default: begin
            ctrl_s.alu_src_a = 1'b0;
            ctrl_s.pc_write  = 1'b1;
            ctrl_s.pc_source = PC_SRC_PC4;
            next_s           = ST_IF;
          end
        endcase
      end
      ST_MEM: begin
        ctrl_s.i_or_d = 1'b1;
        if (cls_s == IC_LOAD) begin
          ctrl_s.mem_read = 1'b1;
          next_s          = done_s ? ST_WB : ST_MEM;
        end else begin
          ctrl_s.mem_write = 1'b1;
          if (done_s) begin
            ctrl_s.pc_write  = 1'b1;
            ctrl_s.pc_source = PC_SRC_PC4;
            next_s           = ST_IF;
          end else begin
            next_s = ST_MEM;
          end
        end
      end
      ST_WB: begin
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.mem_to_reg = (cls_s == IC_LOAD);
        ctrl_s.pc_write   = 1'b1;
        ctrl_s.pc_source  = PC_SRC_PC4;
        next_s            = ST_IF;
      end
      ST_HALT: next_s = ST_HALT;
      default: next_s = ST_IF;
    endcase
  end

  // Strobes are forced low for as long as reset is held, not just from the next edge.
  always_comb begin
    strb_s = ctrl_s;
    if (!reset_n) begin
      strb_s = '0;
    end else begin
      strb_s = ctrl_s;
    end
  end

  assign bus.pc_write   = strb_s.pc_write;
  assign bus.pc_source  = strb_s.pc_source;
  assign bus.ir_write   = strb_s.ir_write;
  assign bus.i_or_d     = strb_s.i_or_d;
  assign bus.mem_read   = strb_s.mem_read;
  assign bus.mem_write  = strb_s.mem_write;
  assign bus.mem_to_reg = strb_s.mem_to_reg;
  assign bus.pc_to_reg  = strb_s.pc_to_reg;
  assign bus.reg_write  = strb_s.reg_write;
  assign bus.alu_src_a  = strb_s.alu_src_a;
  assign bus.alu_src_b  = strb_s.alu_src_b;
  assign bus.alu_op     = strb_s.alu_op;
  assign bus.is_halted  = is_halted_r;
  assign bus.state      = state_r;

`ifdef CTRL_PERF_CNT_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] cycle_cnt_r;
  logic [CNT_WIDTH-1:0] instr_cnt_r;

  // Wrapping performance counters: live cycles and retired instructions.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt_r <= '0;
      instr_cnt_r <= '0;
    end else begin
      cycle_cnt_r <= (state_r != ST_HALT) ? cycle_cnt_r + CNT_ONE : cycle_cnt_r;
      instr_cnt_r <= strb_s.pc_write ? instr_cnt_r + CNT_ONE : instr_cnt_r;
    end
  end

  assign cycle_count = cycle_cnt_r;
  assign instr_count = instr_cnt_r;
`endif

endmodule
